// File: rtl/store_drain_unit.sv
// store_drain_unit: retires the oldest store-buffer entry to the memory port.
// One store is in flight at a time: capture the head, issue the write, wait for
// the ack, then pulse the buffer dequeue. Draining starts when the buffer is
// full, a fence asks for it, occupancy reaches a threshold, or the load
// pipeline has left the port idle long enough.
//
// Handshake: a write request transfers on a rising edge where
// o_mem_req_valid && i_mem_req_ready. Once valid is raised the payload is held
// stable and valid stays high until that transfer. i_mem_ack is a one-cycle
// completion strobe that is only honoured in WAIT_ACK.
module store_drain_unit #(
    parameter int ENTRY_COUNT     = 4,
    parameter int DRAIN_THRESHOLD = 2,
    parameter int IDLE_DRAIN_CYC  = 8,
    parameter int ACK_TIMEOUT     = 64,
    localparam int CNT_W          = $clog2(ENTRY_COUNT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sb_deq_valid,
    input  logic [31:0]      i_sb_deq_addr,
    input  logic [31:0]      i_sb_deq_data,
    input  logic [3:0]       i_sb_deq_wstrb,
    input  logic [CNT_W-1:0] i_sb_count,
    input  logic             i_sb_full,
    input  logic             i_sb_flush,
    output logic             o_sb_deq_req,
    input  logic             i_load_busy,
    input  logic             i_drain_all,
    output logic             o_mem_req_valid,
    input  logic             i_mem_req_ready,
    output logic [31:0]      o_mem_req_addr,
    output logic [31:0]      o_mem_req_data,
    output logic [3:0]       o_mem_req_wstrb,
    input  logic             i_mem_ack,
    output logic             o_drained,
    output logic             o_drain_err,
    output logic [2:0]       o_state
);

    localparam int IW = $clog2(IDLE_DRAIN_CYC + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] THRESHOLD = CNT_W'(DRAIN_THRESHOLD);
    localparam logic [IW-1:0]    IDLE_MAX  = IW'(IDLE_DRAIN_CYC);
    localparam logic [TW-1:0]    TO_MAX    = TW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_RETIRE   = 3'd3,
        S_ERROR    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_idle_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic [TW-1:0]   w_to_next;
    logic            r_abandon;
    logic            r_drain_err;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic [3:0]      r_wstrb;

    logic            w_start;
    logic            w_capture;
    logic            w_to_clr;
    logic            w_to_inc;
    logic            w_abandon_set;
    logic            w_err_set;
    logic            w_deq_req;

    // Drain decision: only meaningful in IDLE; a flush in the same cycle vetoes it.
    assign w_start = i_sb_deq_valid && !i_sb_flush &&
                     (i_sb_full || i_drain_all || (i_sb_count >= THRESHOLD) ||
                      (!i_load_busy && (r_idle_cnt == IDLE_MAX)));

    assign w_to_next = r_to_cnt + TW'(1);

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_to_clr      = 1'b0;
        w_to_inc      = 1'b0;
        w_abandon_set = 1'b0;
        w_err_set     = 1'b0;
        w_deq_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_capture    = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                // The write cannot be withdrawn once offered, so a flush only
                // marks the entry as no longer ours to pop.
                if (i_sb_flush) begin
                    w_abandon_set = 1'b1;
                end
                if (i_mem_req_ready) begin
                    w_to_clr     = 1'b1;
                    w_state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_sb_flush) begin
                    w_abandon_set = 1'b1;
                end
                if (i_mem_ack) begin
                    w_state_next = (r_abandon || i_sb_flush) ? S_IDLE : S_RETIRE;
                end else if (w_to_next == TO_MAX) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_ERROR;
                end else begin
                    w_to_inc = 1'b1;
                end
            end
            S_RETIRE: begin
                w_deq_req    = !i_sb_flush;
                w_state_next = S_IDLE;
            end
            S_ERROR: begin
                w_state_next = S_ERROR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Payload capture at drain start; zeroed on error so ERROR drives a quiet port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_wstrb <= '0;
        end else if (w_err_set) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_wstrb <= '0;
        end else if (w_capture) begin
            r_addr  <= i_sb_deq_addr;
            r_data  <= i_sb_deq_data;
            r_wstrb <= i_sb_deq_wstrb;
        end
    end

    // Load-idle counter: counts quiet cycles with work pending, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idle_cnt <= '0;
        end else if (i_load_busy) begin
            r_idle_cnt <= '0;
        end else if (i_sb_deq_valid && (r_idle_cnt != IDLE_MAX)) begin
            r_idle_cnt <= r_idle_cnt + IW'(1);
        end
    end

    // Ack timeout counter: restarted on the request transfer, advanced in WAIT_ACK.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (w_to_clr) begin
            r_to_cnt <= '0;
        end else if (w_to_inc) begin
            r_to_cnt <= w_to_next;
        end
    end

    // Abandon flag: a flush hit the in-flight entry; cleared once back in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_abandon <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_abandon <= 1'b0;
        end else if (w_abandon_set) begin
            r_abandon <= 1'b1;
        end
    end

    // Sticky timeout error; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drain_err <= 1'b0;
        end else if (w_err_set) begin
            r_drain_err <= 1'b1;
        end
    end

    assign o_mem_req_valid = (r_state == S_REQ);
    assign o_mem_req_addr  = r_addr;
    assign o_mem_req_data  = r_data;
    assign o_mem_req_wstrb = r_wstrb;
    assign o_sb_deq_req    = w_deq_req;
    assign o_drained       = (r_state == S_IDLE) && !i_sb_deq_valid;
    assign o_drain_err     = r_drain_err;
    assign o_state         = r_state;

endmodule

// File: tb/tb_store_drain_unit.sv
// Bench for store_drain_unit: a small store-buffer model feeds the DUT, a
// memory responder answers requests with configurable delays, and a
// scoreboard compares every offered write against the expected head order.
module tb_store_drain_unit;

  localparam int CNT_W = 3;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sb_deq_valid, sb_full, sb_flush, sb_deq_req;
  logic [31:0] sb_deq_addr, sb_deq_data;
  logic [3:0] sb_deq_wstrb;
  logic [CNT_W-1:0] sb_count;
  logic load_busy, drain_all;
  logic mem_req_valid, mem_req_ready, mem_ack;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [3:0] mem_req_wstrb;
  logic drained, drain_err;
  logic [2:0] dbg_state;

  logic [67:0] sb_q[$];
  logic [67:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_pops = 0;
  int valid_len = 0;
  int last_valid_len = 0;
  int cfg_ready_dly = 0;
  int cfg_ack_dly = 0;
  bit cfg_no_ack = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  store_drain_unit dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_sb_deq_valid(sb_deq_valid), .i_sb_deq_addr(sb_deq_addr),
    .i_sb_deq_data(sb_deq_data), .i_sb_deq_wstrb(sb_deq_wstrb),
    .i_sb_count(sb_count), .i_sb_full(sb_full), .i_sb_flush(sb_flush),
    .o_sb_deq_req(sb_deq_req), .i_load_busy(load_busy), .i_drain_all(drain_all),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready),
    .o_mem_req_addr(mem_req_addr), .o_mem_req_data(mem_req_data),
    .o_mem_req_wstrb(mem_req_wstrb), .i_mem_ack(mem_ack),
    .o_drained(drained), .o_drain_err(drain_err), .o_state(dbg_state)
  );

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_refresh();
    sb_deq_valid = (sb_q.size() != 0);
    sb_count = CNT_W'(sb_q.size());
    sb_full = (sb_q.size() == 4);
    if (sb_q.size() != 0) {sb_deq_addr, sb_deq_data, sb_deq_wstrb} = sb_q[0];
    else {sb_deq_addr, sb_deq_data, sb_deq_wstrb} = '0;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    sb_q.push_back({a, d, s});
    exp_q.push_back({a, d, s});
    sb_refresh();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == st) break;
      tick();
    end
    check(tag, 68'(dbg_state), 68'(st));
  endtask

  task automatic wait_idle_empty(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (drained && exp_q.size() == 0) break;
      tick();
    end
    check(tag, 68'(drained && exp_q.size() == 0), 68'(1));
  endtask

  // memory responder: ready after cfg_ready_dly cycles, ack cfg_ack_dly cycles after transfer
  initial begin
    mem_req_ready = 1'b0;
    mem_ack = 1'b0;
    forever begin
      tick();
      if (rst_n && mem_req_valid) begin
        repeat (cfg_ready_dly) tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        if (!cfg_no_ack) begin
          repeat (cfg_ack_dly) tick();
          mem_ack = 1'b1;
          tick();
          mem_ack = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor and store-buffer pop, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        valid_len = 0;
        continue;
      end
      if (mem_req_valid) begin
        valid_len++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 68'(1), 68'(0));
        end else begin
          check("req_payload", {mem_req_addr, mem_req_data, mem_req_wstrb}, exp_q[0]);
          if (mem_req_ready) begin
            exp_q.delete(0);
            last_valid_len = valid_len;
            valid_len = 0;
          end
        end
      end
      if (sb_deq_req) begin
        n_pops++;
        if (sb_q.size() != 0) sb_q.delete(0);
        sb_refresh();
      end
    end
  end

  initial begin
    int n;
    int p0;
    int vcount;
    sb_flush = 1'b0;
    load_busy = 1'b0;
    drain_all = 1'b0;
    sb_refresh();

    // 1: reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_flags", 68'({mem_req_valid, sb_deq_req, drain_err}), 68'(0));
    check("rst_payload", {mem_req_addr, mem_req_data, mem_req_wstrb}, 68'(0));
    rst_n = 1'b1;
    tick();
    check("rst_drained", 68'(drained), 68'(1));
    check("rst_state", 68'(dbg_state), 68'(ST_IDLE));

    // 2: threshold start with loads busy; pop 3 cycles after start
    load_busy = 1'b1;
    p0 = n_pops;
    push_store(32'h100, 32'hDEADBEEF, 4'hF);
    push_store(32'h104, 32'h12345678, 4'h3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (sb_deq_req) break;
    end
    check("t2_pop_latency", 68'(n), 68'(3));
    check("t2_valid_len", 68'(last_valid_len), 68'(1));
    repeat (10) tick();
    check("t2_below_thr_pops", 68'(n_pops - p0), 68'(1));
    check("t2_below_thr_left", 68'(exp_q.size()), 68'(1));
    drain_all = 1'b1;
    wait_idle_empty("t2_drain_all", 40);
    drain_all = 1'b0;
    check("t2_pops", 68'(n_pops - p0), 68'(2));

    // 3: single entry, idle-drain after 8 load-free cycles
    p0 = n_pops;
    push_store(32'h200, 32'hA5A5_0001, 4'h8);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req_valid) vcount++;
    end
    check("t3_no_req_busy", 68'(vcount), 68'(0));
    load_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (mem_req_valid) break;
    end
    check("t3_idle_latency", 68'(n), 68'(9));
    wait_idle_empty("t3_drain", 40);
    check("t3_pops", 68'(n_pops - p0), 68'(1));

    // 4: ready withheld 5 cycles
    cfg_ready_dly = 5;
    drain_all = 1'b1;
    p0 = n_pops;
    push_store(32'h300, 32'h0BAD_F00D, 4'h6);
    wait_idle_empty("t4_drain", 60);
    check("t4_valid_len", 68'(last_valid_len), 68'(6));
    check("t4_pops", 68'(n_pops - p0), 68'(1));
    cfg_ready_dly = 0;
    drain_all = 1'b0;

    // 5: flush while waiting for the ack
    cfg_ack_dly = 3;
    drain_all = 1'b1;
    p0 = n_pops;
    push_store(32'h400, 32'h1111_2222, 4'hF);
    wait_state("t5_reach_wait", ST_WAIT, 20);
    sb_flush = 1'b1;
    tick();
    sb_flush = 1'b0;
    sb_q.delete();
    sb_refresh();
    drain_all = 1'b0;
    wait_state("t5_back_idle", ST_IDLE, 20);
    repeat (4) tick();
    check("t5_no_pop", 68'(n_pops - p0), 68'(0));
    check("t5_no_req", 68'(mem_req_valid), 68'(0));
    cfg_ack_dly = 0;
    drain_all = 1'b1;
    push_store(32'h500, 32'hCAFE_F00D, 4'h5);
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid) break;
      tick();
    end
    check("t5_new_head", {mem_req_addr, mem_req_data, mem_req_wstrb}, {32'h500, 32'hCAFE_F00D, 4'h5});
    wait_idle_empty("t5_drain", 40);
    check("t5_pops", 68'(n_pops - p0), 68'(1));
    drain_all = 1'b0;

    // 6: ack timeout
    cfg_no_ack = 1'b1;
    drain_all = 1'b1;
    p0 = n_pops;
    push_store(32'h600, 32'h6666_7777, 4'h1);
    wait_state("t6_reach_wait", ST_WAIT, 20);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (drain_err) break;
      tick();
      n++;
    end
    check("t6_timeout_cycles", 68'(n), 68'(64));
    drain_all = 1'b0;
    sb_q.delete();
    sb_refresh();
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req_valid || sb_deq_req || !drain_err || dbg_state != ST_ERROR) vcount++;
    end
    check("t6_error_quiet", 68'(vcount), 68'(0));
    check("t6_error_payload", {mem_req_addr, mem_req_data, mem_req_wstrb}, 68'(0));
    check("t6_no_pop", 68'(n_pops - p0), 68'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_err", 68'(drain_err), 68'(0));
    check("t6_rst_state", 68'(dbg_state), 68'(ST_IDLE));
    cfg_no_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 7: full burst with loads busy drains down to one entry, then idle drain
    load_busy = 1'b1;
    cfg_ready_dly = $urandom_range(0, 2);
    cfg_ack_dly = $urandom_range(0, 2);
    p0 = n_pops;
    for (int i = 0; i < 4; i++) push_store($urandom, $urandom, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 120; i++) begin
      if (n_pops - p0 >= 3) break;
      tick();
    end
    repeat (15) tick();
    check("t7_busy_pops", 68'(n_pops - p0), 68'(3));
    check("t7_residual", 68'(exp_q.size()), 68'(1));
    load_busy = 1'b0;
    wait_idle_empty("t7_drain", 60);
    check("t7_pops", 68'(n_pops - p0), 68'(4));
    check("final_exp_q_empty", 68'(exp_q.size()), 68'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
